// File: rtl/serial_bus_arbiter_nxm_pkg.sv
// serial_bus_pkg: shared definitions for the N x M serial bus arbiter.
//   state_e      - arbiter FSM encoding (also exported on the debug state port)
//   ERR_*        - reason codes behind an m_err pulse
//   sb_clog2     - ceil(log2(value)), never less than 1, for counter/index widths
package serial_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_CONNECT = 3'd2,
        ST_BUSY    = 3'd3,
        ST_RESUME  = 3'd4
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DECODE  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    function automatic int sb_clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_bus_arbiter_nxm_if.sv
// Bus bundle between the arbiter and the masters/slaves.
//   master modport : the arbiter's view (drives grants, crossbar outputs, debug state)
//   slave modport  : the environment's view (drives requests, serial bits, slave status)
interface serial_bus_arbiter_nxm_if #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 3
);
    logic [NUM_MASTERS-1:0] m_req, m_addr, m_data, m_valid, m_wen, m_burst;
    logic [NUM_MASTERS-1:0] m_grant, m_ready, m_rdata, m_rvalid, m_err;
    logic [NUM_SLAVES-1:0]  s_ready, s_hold, s_rdata, s_rvalid;
    logic [NUM_SLAVES-1:0]  s_addr, s_data, s_valid, s_wen, s_burst, s_bus_ready;
    logic [2:0]             state;

    modport master (
        input  m_req, m_addr, m_data, m_valid, m_wen, m_burst,
        input  s_ready, s_hold, s_rdata, s_rvalid,
        output m_grant, m_ready, m_rdata, m_rvalid, m_err,
        output s_addr, s_data, s_valid, s_wen, s_burst, s_bus_ready,
        output state
    );

    modport slave (
        output m_req, m_addr, m_data, m_valid, m_wen, m_burst,
        output s_ready, s_hold, s_rdata, s_rvalid,
        input  m_grant, m_ready, m_rdata, m_rvalid, m_err,
        input  s_addr, s_data, s_valid, s_wen, s_burst, s_bus_ready,
        input  state
    );
endinterface

// File: rtl/serial_bus_arbiter_nxm_rr_arbiter.sv
// rr_arbiter: combinational request picker.
//   i_req/i_mask : requests, and a mask clearing masters that may not win
//   i_ptr        : round-robin start index (ignored when RR_MODE=0)
//   o_valid      : some unmasked request exists
//   o_idx        : winner index (first set request at or after the start index)
module rr_arbiter #(
    parameter int N       = 2,
    parameter int RR_MODE = 0,
    parameter int IW      = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [N-1:0]  i_mask,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);
    logic [N-1:0]  w_req;
    logic [N-1:0]  w_rot;
    logic [IW-1:0] w_base;

    assign w_req  = i_req & i_mask;
    assign w_base = (RR_MODE != 0) ? i_ptr : '0;
    // Rotate so bit k of w_rot is request (w_base + k) mod N.
    assign w_rot  = N'({w_req, w_req} >> w_base);

    // Scan from the far end so the lowest rotated position overwrites last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            o_idx   = w_rot[k] ? IW'((int'(w_base) + k) % N) : o_idx;
            o_valid = o_valid | w_rot[k];
        end
    end
endmodule

// File: rtl/serial_bus_arbiter_nxm.sv
// serial_bus_arbiter_nxm: N-master x M-slave arbiter and crossbar.
//   clk, reset : clock, synchronous active-high reset
//   bus        : master modport of serial_bus_arbiter_nxm_if (requests, serial
//                select/data, grants, crossbar paths, m_err pulses, debug state)
// A winning master shifts SEL_BITS select bits MSB first, then is connected to
// that slave once it is ready. A slave raising s_hold lets one other master use
// the bus; the parked master is then reconnected directly through RESUME.
module serial_bus_arbiter_nxm
    import serial_bus_pkg::*;
#(
    parameter int NUM_MASTERS   = 2,
    parameter int NUM_SLAVES    = 3,
    parameter int SEL_BITS      = 2,
    parameter int RR_MODE       = 0,
    parameter int READY_TIMEOUT = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    serial_bus_arbiter_nxm_if.master bus
);
    localparam int OW = sb_clog2(NUM_MASTERS);
    localparam int BW = sb_clog2(SEL_BITS + 1);
    localparam int WW = sb_clog2(READY_TIMEOUT + 1);

    state_e                 r_state, w_state_nxt;
    logic [OW-1:0]          r_owner, w_owner_nxt, r_park_owner, w_park_owner_nxt;
    logic [OW-1:0]          r_rr_ptr, w_ptr_nxt;
    logic [SEL_BITS-1:0]    r_sel, w_sel_nxt, r_park_sel, w_park_sel_nxt;
    logic [BW-1:0]          r_bitcnt, w_bitcnt_nxt;
    logic [WW-1:0]          r_wait, w_wait_nxt;
    logic                   r_parked, w_parked_nxt;
    logic [NUM_MASTERS-1:0] r_err, w_err_nxt;
    logic [1:0]             w_err_code;

    logic [NUM_MASTERS-1:0] w_owner_hot, w_arb_mask;
    logic [NUM_SLAVES-1:0]  w_sel_hot;
    logic                   w_sel_ok, w_slv_ready, w_slv_hold, w_path;
    logic                   w_req_bit, w_addr_bit, w_data_bit, w_valid_bit, w_wen_bit, w_burst_bit;
    logic                   w_arb_valid;
    logic [OW-1:0]          w_arb_idx;

    assign w_owner_hot = NUM_MASTERS'(1'b1) << r_owner;
    // An out-of-range select shifts the one-hot to zero, so no slave is touched.
    assign w_sel_hot   = NUM_SLAVES'(1'b1) << r_sel;
    assign w_sel_ok    = int'(r_sel) < NUM_SLAVES;
    assign w_slv_ready = |(bus.s_ready & w_sel_hot);
    assign w_slv_hold  = |(bus.s_hold & w_sel_hot);

    assign w_req_bit   = |(bus.m_req   & w_owner_hot);
    assign w_addr_bit  = |(bus.m_addr  & w_owner_hot);
    assign w_data_bit  = |(bus.m_data  & w_owner_hot);
    assign w_valid_bit = |(bus.m_valid & w_owner_hot);
    assign w_wen_bit   = |(bus.m_wen   & w_owner_hot);
    assign w_burst_bit = |(bus.m_burst & w_owner_hot);

    // At a split the current owner must not win again; in IDLE everyone competes.
    assign w_arb_mask = (r_state == ST_BUSY) ? ~w_owner_hot : '1;

    rr_arbiter #(
        .N       (NUM_MASTERS),
        .RR_MODE (RR_MODE),
        .IW      (OW)
    ) u_arb (
        .i_req   (bus.m_req),
        .i_mask  (w_arb_mask),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_arb_valid),
        .o_idx   (w_arb_idx)
    );

    // Crossbar: one path, closed only in BUSY or CONNECT with the slave ready.
    assign w_path          = (r_state == ST_BUSY) ||
                             ((r_state == ST_CONNECT) && w_sel_ok && w_slv_ready);
    assign bus.m_grant     = ((r_state == ST_ADDR) || (r_state == ST_CONNECT) ||
                              (r_state == ST_BUSY)) ? w_owner_hot : '0;
    assign bus.m_ready     = {NUM_MASTERS{w_path & w_slv_ready}} & w_owner_hot;
    assign bus.m_rdata     = {NUM_MASTERS{w_path & (|(bus.s_rdata  & w_sel_hot))}} & w_owner_hot;
    assign bus.m_rvalid    = {NUM_MASTERS{w_path & (|(bus.s_rvalid & w_sel_hot))}} & w_owner_hot;
    assign bus.m_err       = r_err;
    assign bus.s_addr      = {NUM_SLAVES{w_path & w_addr_bit}}  & w_sel_hot;
    assign bus.s_data      = {NUM_SLAVES{w_path & w_data_bit}}  & w_sel_hot;
    assign bus.s_valid     = {NUM_SLAVES{w_path & w_valid_bit}} & w_sel_hot;
    assign bus.s_wen       = {NUM_SLAVES{w_path & w_wen_bit}}   & w_sel_hot;
    assign bus.s_burst     = {NUM_SLAVES{w_path & w_burst_bit}} & w_sel_hot;
    assign bus.s_bus_ready = w_path ? w_sel_hot : '1;
    assign bus.state       = r_state;

    // Next-state and next-register logic for the arbiter FSM.
    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_sel_nxt        = r_sel;
        w_bitcnt_nxt     = r_bitcnt;
        w_wait_nxt       = r_wait;
        w_parked_nxt     = r_parked;
        w_park_owner_nxt = r_park_owner;
        w_park_sel_nxt   = r_park_sel;
        w_ptr_nxt        = r_rr_ptr;
        w_err_code       = ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (r_parked) begin
                    // A parked master outranks fresh requests.
                    w_state_nxt = ST_RESUME;
                end else if (w_arb_valid) begin
                    w_owner_nxt  = w_arb_idx;
                    w_ptr_nxt    = (int'(w_arb_idx) == NUM_MASTERS - 1) ? '0 : w_arb_idx + OW'(1);
                    w_sel_nxt    = '0;
                    w_bitcnt_nxt = '0;
                    w_state_nxt  = ST_ADDR;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (w_valid_bit) begin
                    w_sel_nxt    = (r_sel << 1) | SEL_BITS'(w_addr_bit);
                    w_bitcnt_nxt = r_bitcnt + BW'(1);
                    if (r_bitcnt == BW'(SEL_BITS - 1)) begin
                        w_wait_nxt  = '0;
                        w_state_nxt = ST_CONNECT;
                    end else begin
                        w_state_nxt = ST_ADDR;
                    end
                end else begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_CONNECT: begin
                if (!w_sel_ok) begin
                    w_err_code  = ERR_DECODE;
                    w_state_nxt = ST_IDLE;
                end else if (w_slv_ready) begin
                    w_state_nxt = ST_BUSY;
                end else if (r_wait == WW'(READY_TIMEOUT - 1)) begin
                    w_err_code  = ERR_TIMEOUT;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wait_nxt = r_wait + WW'(1);
                end
            end
            ST_BUSY: begin
                if (!w_req_bit) begin
                    w_state_nxt = r_parked ? ST_RESUME : ST_IDLE;
                end else if (w_slv_hold && !r_parked && w_arb_valid) begin
                    w_parked_nxt     = 1'b1;
                    w_park_owner_nxt = r_owner;
                    w_park_sel_nxt   = r_sel;
                    w_owner_nxt      = w_arb_idx;
                    w_ptr_nxt        = (int'(w_arb_idx) == NUM_MASTERS - 1) ? '0 : w_arb_idx + OW'(1);
                    w_sel_nxt        = '0;
                    w_bitcnt_nxt     = '0;
                    w_state_nxt      = ST_ADDR;
                end else begin
                    w_state_nxt = ST_BUSY;
                end
            end
            ST_RESUME: begin
                w_owner_nxt  = r_park_owner;
                w_sel_nxt    = r_park_sel;
                w_parked_nxt = 1'b0;
                w_wait_nxt   = '0;
                w_state_nxt  = ST_CONNECT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        w_err_nxt = (w_err_code != ERR_NONE) ? w_owner_hot : '0;
    end

    // FSM and datapath registers; owner/sel are dropped on every return to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_sel        <= '0;
            r_bitcnt     <= '0;
            r_wait       <= '0;
            r_parked     <= 1'b0;
            r_park_owner <= '0;
            r_park_sel   <= '0;
            r_rr_ptr     <= '0;
            r_err        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= (w_state_nxt == ST_IDLE) ? '0 : w_owner_nxt;
            r_sel        <= (w_state_nxt == ST_IDLE) ? '0 : w_sel_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_wait       <= w_wait_nxt;
            r_parked     <= w_parked_nxt;
            r_park_owner <= w_park_owner_nxt;
            r_park_sel   <= w_park_sel_nxt;
            r_rr_ptr     <= w_ptr_nxt;
            r_err        <= w_err_nxt;
        end
    end
endmodule

// File: doc/serial_bus_arbiter_nxm.md
Name: serial_bus_arbiter_nxm

Overview:
Parametrised N-master × M-slave arbiter and crossbar for the serial bus. Masters request the bus and shift a slave-select field serially, MSB first, on their address line. The arbiter then connects the winning master to the selected slave. Compared with the fixed 2×3 arbiter it adds configurable master/slave counts, selectable fixed-priority or round-robin arbitration, decode-error reporting, a bounded wait for slave ready, and one outstanding split transaction.

Parameters:
NUM_MASTERS, 2, number of masters (2..8)
NUM_SLAVES, 3, number of slaves (1..8)
SEL_BITS, 2, serial slave-select width; must satisfy 2**SEL_BITS >= NUM_SLAVES
RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
READY_TIMEOUT, 15, maximum cycles spent in CONNECT waiting for s_ready

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
m_req  in  NUM_MASTERS  bus request per master
m_addr  in  NUM_MASTERS  serial address bit per master
m_data  in  NUM_MASTERS  serial write data per master
m_valid  in  NUM_MASTERS  address/data bit valid per master
m_wen  in  NUM_MASTERS  write enable per master
m_burst  in  NUM_MASTERS  burst flag per master
m_grant  out  NUM_MASTERS  one-hot; the master currently owns the bus (ADDR, CONNECT, BUSY)
m_ready  out  NUM_MASTERS  s_ready of the connected slave
m_rdata  out  NUM_MASTERS  read data from the connected slave
m_rvalid  out  NUM_MASTERS  read valid from the connected slave
m_err  out  NUM_MASTERS  one-cycle pulse: decode error or ready timeout
s_ready  in  NUM_SLAVES  slave ready
s_hold  in  NUM_SLAVES  slave requests a split (long latency)
s_rdata  in  NUM_SLAVES  read data per slave
s_rvalid  in  NUM_SLAVES  read valid per slave
s_addr, s_data, s_wen, s_burst  out  NUM_SLAVES each  forwarded from the connected master, 0 otherwise
s_valid  out  NUM_SLAVES  forwarded m_valid; forced 0 while in ADDR
s_bus_ready  out  NUM_SLAVES  1 unless a different slave is connected
state  out  3  FSM state, for debug

Behaviour:
- Reset:
  - State goes to IDLE.
  - All m_* outputs and s_addr/s_data/s_valid/s_wen/s_burst are 0; s_bus_ready is all 1s.
  - The split record is cleared and the RR pointer is set to 0.
  - Reset mid-transfer drops the connection on the next edge.
- States: IDLE=0, ADDR=1, CONNECT=2, BUSY=3, RESUME=4.
- IDLE:
  - If any m_req is high, the arbiter picks a winner and registers it as owner; next state is ADDR.
  - RR_MODE=1: the search starts at the RR pointer, and the pointer becomes winner+1 (mod N).
  - RR_MODE=0: lowest index wins.
- ADDR:
  - Each cycle with m_valid[owner]=1, m_addr[owner] is shifted into sel and the bit counter increments. Cycles with m_valid low stall the counter.
  - After SEL_BITS accepted bits, next state is CONNECT.
- CONNECT:
  - If sel >= NUM_SLAVES: m_err[owner] pulses, next state is IDLE.
  - Else if s_ready[sel]=1: crossbar path closes, next state is BUSY. The first forwarded cycle is the cycle after entry.
  - Else the wait counter increments. When it reaches READY_TIMEOUT: m_err pulses, next state is IDLE.
- BUSY (first matching rule wins):
  - m_req[owner] low and split parked: next state is RESUME.
  - m_req[owner] low, no split parked: next state is IDLE.
  - s_hold[sel]=1, no split parked, and another master requests:
    - owner and sel are saved as the parked pair;
    - a new owner is arbitrated from the other requesters;
    - next state is ADDR.
  - A second split while one is parked is ignored; state stays BUSY.
- RESUME:
  - The parked master becomes owner with its stored sel; the split record is cleared.
  - Next state is CONNECT (ADDR is skipped).
  - The parked master outranks all IDLE arbitration.
- Crossbar:
  - Combinational from the registered owner/sel.
  - Exactly one master-slave path is active, and only in CONNECT-with-ready and in BUSY.
  - Unconnected outputs are 0.
- The m_err pulse is exactly one cycle; owner and sel are cleared on any return to IDLE.

Decomposition:
- Package serial_bus_pkg holds:
  - the state enum constants (IDLE..RESUME);
  - the SEL_BITS derivation helper (clog2);
  - the error code constants.
- One sub-module, rr_arbiter (parametrised N, fixed/RR mode, mask input excluding the current owner), is used in IDLE and at split.

Test Plan:
1. Default params. m_req=2'b01, m_addr bits 1,0 on two m_valid cycles, s_ready[2]=1 → m_grant=01, state 0→1→2→3, s3 path active, s_valid low during ADDR.
2. RR_MODE=1, both masters requesting continuously over 4 transactions → grants alternate M0, M1, M0, M1. With RR_MODE=0 → M0 every time.
3. Address bits 1,1 (sel=3) with NUM_SLAVES=3 → m_err[owner] high exactly one cycle, then IDLE, no s_* activity.
4. s_ready[sel]=0 held → after READY_TIMEOUT=15 cycles in CONNECT, m_err pulses and state returns to IDLE. If ready arrives at cycle 5 instead → state goes to BUSY.
5. M0 in BUSY on S1 with s_hold[0]=1 while M1 requests S2 → M1 addressed and connected. When M1 drops m_req → RESUME, then M0 is reconnected to S1 without an ADDR phase.
6. Assert reset during BUSY → the next cycle shows state=0, all m_grant/s_* outputs 0, s_bus_ready=3'b111, split record cleared.
